// File: rtl/alu_sequencer.sv
// Issue stage ahead of the 16-bit ALU: decode, 32-bit add/sub sequencing, compare fixup.
// Define ALU_SEQ_CMP_EN to build SEQ/SLT; otherwise codes 10/11 are illegal.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_op,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ofl,
  output logic        out_zero,
  output logic        out_err
);

  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC_LO, S_EXEC_HI, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_LOGIC, K_ARITH, K_SEQ, K_SLT, K_WIDE, K_ILL
  } kind_t;

  state_t      r_state;
  kind_t       r_kind;
  logic [15:0] r_a_hi;
  logic [15:0] r_b_hi;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic        r_alu_cin;
  logic [2:0]  r_alu_op;
  logic        r_alu_inva;
  logic        r_alu_invb;
  logic        r_alu_sign;
  logic [31:0] r_out_data;
  logic        r_out_ofl;
  logic        r_out_zero;
  logic        r_out_err;

  kind_t       w_kind;
  logic [2:0]  w_op;
  logic        w_invb;
  logic        w_cin;
  logic        w_sign;
  logic [15:0] w_res16;
  logic        w_ofl16;

  always_comb begin
    w_kind = K_LOGIC;
    w_op   = in_func[2:0];
    w_invb = 1'b0;
    w_cin  = 1'b0;
    w_sign = 1'b0;
    case (in_func)
      4'd4: begin
        w_sign = 1'b1;
        w_kind = K_ARITH;
      end
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd5, 4'd6, 4'd7: w_kind = K_LOGIC;
      4'd8: begin
        w_op   = OP_ADD;
        w_invb = 1'b1;
        w_cin  = 1'b1;
        w_sign = 1'b1;
        w_kind = K_ARITH;
      end
      4'd9: begin
        w_op   = OP_AND;
        w_invb = 1'b1;
      end
`ifdef ALU_SEQ_CMP_EN
      4'd10, 4'd11: begin
        w_op   = OP_ADD;
        w_invb = 1'b1;
        w_cin  = 1'b1;
        w_sign = 1'b1;
        w_kind = in_func[0] ? K_SLT : K_SEQ;
      end
`endif
      4'd12: begin
        w_op   = OP_ADD;
        w_kind = K_WIDE;
      end
      4'd13: begin
        w_op   = OP_ADD;
        w_invb = 1'b1;
        w_cin  = 1'b1;
        w_kind = K_WIDE;
      end
      default: w_kind = K_ILL;
    endcase
  end

  // Compare results are rebuilt from the subtract flags.
  always_comb begin
    w_res16 = alu_out;
    w_ofl16 = 1'b0;
    case (r_kind)
      K_ARITH: w_ofl16 = alu_ofl;
`ifdef ALU_SEQ_CMP_EN
      K_SEQ:   w_res16 = {15'd0, alu_zero};
      K_SLT:   w_res16 = {15'd0, alu_out[15] ^ alu_ofl};
`endif
      default: w_ofl16 = 1'b0;
    endcase
  end

`ifndef ALU_SEQ_CMP_EN
  logic w_unused_zero;
  assign w_unused_zero = alu_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_kind     <= K_LOGIC;
      r_a_hi     <= '0;
      r_b_hi     <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_op   <= '0;
      r_alu_inva <= 1'b0;
      r_alu_invb <= 1'b0;
      r_alu_sign <= 1'b0;
      r_out_data <= '0;
      r_out_ofl  <= 1'b0;
      r_out_zero <= 1'b0;
      r_out_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_kind     <= w_kind;
            r_out_data <= '0;
            r_out_ofl  <= 1'b0;
            if (w_kind == K_ILL) begin
              r_out_err  <= 1'b1;
              r_out_zero <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_out_err  <= 1'b0;
              r_out_zero <= 1'b0;
              r_alu_a    <= in_a[15:0];
              r_alu_b    <= in_b[15:0];
              r_a_hi     <= in_a[31:16];
              r_b_hi     <= in_b[31:16];
              r_alu_op   <= w_op;
              r_alu_inva <= 1'b0;
              r_alu_invb <= w_invb;
              r_alu_cin  <= w_cin;
              r_alu_sign <= w_sign;
              r_state    <= S_EXEC_LO;
            end
          end
        end
        S_EXEC_LO: begin
          if (r_kind == K_WIDE) begin
            // With sign=0 the ofl flag is the adder carry-out.
            r_out_data[15:0] <= alu_out;
            r_alu_cin        <= alu_ofl;
            r_alu_a          <= r_a_hi;
            r_alu_b          <= r_b_hi;
            r_alu_sign       <= 1'b1;
            r_state          <= S_EXEC_HI;
          end else begin
            r_out_data <= {16'd0, w_res16};
            r_out_ofl  <= w_ofl16;
            r_out_zero <= (w_res16 == 16'd0);
            r_state    <= S_DONE;
          end
        end
        S_EXEC_HI: begin
          r_out_data[31:16] <= alu_out;
          r_out_ofl         <= alu_ofl;
          r_out_zero        <= (alu_out == 16'd0) &&
                               (r_out_data[15:0] == 16'd0);
          r_state           <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_ofl   = r_out_ofl;
  assign out_zero  = r_out_zero;
  assign out_err   = r_out_err;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_op    = r_alu_op;
  assign alu_invA  = r_alu_inva;
  assign alu_invB  = r_alu_invb;
  assign alu_sign  = r_alu_sign;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 16-bit ALU attached.
// Honours ALU_SEQ_CMP_EN the same way as the design.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [2:0]  alu_op;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_out;
  logic        alu_ofl;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ofl;
  logic        out_zero;
  logic        out_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_invA(alu_invA), .alu_invB(alu_invB),
    .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ofl(out_ofl),
    .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ofl is signed overflow when sign=1, carry-out otherwise.
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [16:0] m_sum;
  logic [31:0] m_rot;
  always_comb begin
    m_a   = alu_invA ? ~alu_a : alu_a;
    m_b   = alu_invB ? ~alu_b : alu_b;
    m_sum = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_cin};
    m_rot = '0;
    alu_ofl = 1'b0;
    case (alu_op)
      3'd0: begin
        m_rot   = {m_a, m_a} << alu_b[3:0];
        alu_out = m_rot[31:16];
      end
      3'd1: alu_out = m_a << alu_b[3:0];
      3'd2: begin
        m_rot   = {m_a, m_a} >> alu_b[3:0];
        alu_out = m_rot[15:0];
      end
      3'd3: alu_out = $signed(m_a) >>> alu_b[3:0];
      3'd4: begin
        alu_out = m_sum[15:0];
        alu_ofl = alu_sign ?
          ((m_a[15] == m_b[15]) && (m_sum[15] != m_a[15])) : m_sum[16];
      end
      3'd5: alu_out = m_a | m_b;
      3'd6: alu_out = m_a ^ m_b;
      default: alu_out = m_a & m_b;
    endcase
    alu_zero = (alu_out == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge clk);
    in_func  = f;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input int elat, input logic [31:0] edata,
                     input logic eofl, input logic ezero,
                     input logic eerr);
    int lat;
    issue(f, a, b, lat);
    chk({tag, ".lat"},  lat, elat);
    chk({tag, ".data"}, out_data, edata);
    chk({tag, ".ofl"},  {31'd0, out_ofl}, {31'd0, eofl});
    chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, ezero});
    chk({tag, ".err"},  {31'd0, out_err}, {31'd0, eerr});
    take(tag);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_func   = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #2;
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data",  out_data, 32'd0);
    chk("rst.alu_op",    {29'd0, alu_op}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst.ready_after", {31'd0, in_ready}, 32'd1);

    run("add",  4'd4,  32'h0123, 32'h0234, 1, 32'h0000_0357, 0, 0, 0);
    run("sub",  4'd8,  32'd20000, 32'h0000_B1E0, 1,
        32'h0000_9C40, 1, 0, 0);
    run("add32", 4'd12, 32'h0000_FFFF, 32'h1, 2,
        32'h0001_0000, 0, 0, 0);
    run("sub32", 4'd13, 32'h0001_0000, 32'h1, 2,
        32'h0000_FFFF, 0, 0, 0);
    run("sub32z", 4'd13, 32'h1234_5678, 32'h1234_5678, 2,
        32'h0, 0, 1, 0);
    run("rol",  4'd0,  32'h8001, 32'h1, 1, 32'h0000_0003, 0, 0, 0);
    run("sra",  4'd3,  32'h8000, 32'h4, 1, 32'h0000_F800, 0, 0, 0);
    run("andn", 4'd9,  32'hFF0F, 32'h0F0F, 1, 32'h0000_F000, 0, 0, 0);
    run("xor0", 4'd6,  32'h5A5A, 32'h5A5A, 1, 32'h0, 0, 1, 0);
`ifdef ALU_SEQ_CMP_EN
    run("slt",  4'd11, 32'hFFF6, 32'h0014, 1, 32'h1, 0, 0, 0);
    run("seq",  4'd10, 32'h1234, 32'h1234, 1, 32'h1, 0, 0, 0);
    run("seqn", 4'd10, 32'h1234, 32'h1235, 1, 32'h0, 0, 1, 0);
`else
    run("ill10", 4'd10, 32'h1234, 32'h1234, 0, 32'h0, 0, 1, 1);
`endif
    run("ill15", 4'd15, 32'h1234, 32'h5678, 0, 32'h0, 0, 1, 1);

    issue(4'd1, 32'h00EA, 32'h4, lat);
    chk("bp.lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp.data",  out_data, 32'h0000_0EA0);
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    take("bp");

    @(negedge clk);
    in_func  = 4'd12;
    in_a     = 32'h0005_0001;
    in_b     = 32'h0003_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 chk("rst.hi_pass", {16'd0, alu_a}, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.vld",  {31'd0, out_valid}, 32'd0);
    chk("rst.data", out_data, 32'd0);
    chk("rst.alu",  {alu_a, alu_b}, 32'd0);
    chk("rst.ctl",  {25'd0, alu_cin, alu_op, alu_invA, alu_invB,
                     alu_sign}, 32'd0);
    chk("rst.flags", {29'd0, out_ofl, out_zero, out_err}, 32'd0);
    chk("rst.rdy",  {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst.idle", {31'd0, in_ready}, 32'd1);
    run("post", 4'd4, 32'd10, 32'd20, 1, 32'd30, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
